// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode definitions for the decode, execute and ALU
// blocks. Holds opcode/funct encodings, the ALU function enum, control-bus
// bit positions, immediate-extension helpers and the ID->EX bundle struct.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'ha
  } alu_funct_t;

  // control[3:0] is the ALU funct; these two select the B-side operand source
  localparam int CTL_USE_IMM   = 4;
  localparam int CTL_USE_SHAMT = 5;

  // Bundle registered at the ID/EX boundary
  typedef struct packed {
    logic [5:0]  control;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] vs;
    logic [31:0] vt;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } id_bundle_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake bundle around the ID stage.
//   Fetch side : in_valid/in_ready, instr, pc_in, flush
//   Execute side: out_valid/out_ready, control, rd, shamt, vs, vt, imm,
//                 pc_out, illegal
// slave  = the decode stage itself; master = the surrounding fetch/execute.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  control;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] vs;
  logic [31:0] vt;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;

  modport slave (
    input  in_valid, instr, pc_in, flush, out_ready,
    output in_ready, out_valid, control, rd, shamt, vs, vt, imm, pc_out, illegal
  );

  modport master (
    output in_valid, instr, pc_in, flush, out_ready,
    input  in_ready, out_valid, control, rd, shamt, vs, vt, imm, pc_out, illegal
  );
endinterface

// File: rtl/decode_stage_decoder.sv
// instr_decoder: purely combinational decode of the integer ALU subset.
//   instr   in  instruction word
//   rs, rt  out source register fields (register file read addresses)
//   control out {use_shamt, use_imm, alu_funct}
//   rd      out destination register
//   shamt   out shift amount (0 for non-shifts)
//   imm     out extended immediate
//   illegal out unsupported encoding; all other outputs forced to a NOP
//   zero_vs out rs operand must be replaced by 0 (LUI)
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [5:0]  control,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [31:0] imm,
  output logic        illegal,
  output logic        zero_vs
);

  logic [5:0] op, fn;
  alu_funct_t f;
  logic       use_imm, use_shamt, legal;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];

  always_comb begin
    f         = ALU_ADD;
    use_imm   = 1'b0;
    use_shamt = 1'b0;
    legal     = 1'b1;
    rd        = instr[15:11];
    shamt     = 5'd0;
    imm       = 32'h0;
    zero_vs   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU: f = ALU_ADD;
          FN_SUBU: f = ALU_SUB;
          FN_AND:  f = ALU_AND;
          FN_OR:   f = ALU_OR;
          FN_XOR:  f = ALU_XOR;
          FN_NOR:  f = ALU_NOR;
          FN_SLT:  f = ALU_SLT;
          FN_SLTU: f = ALU_SLTU;
          FN_SLL:  begin f = ALU_SLL; use_shamt = 1'b1; shamt = instr[10:6]; end
          FN_SRL:  begin f = ALU_SRL; use_shamt = 1'b1; shamt = instr[10:6]; end
          FN_SRA:  begin f = ALU_SRA; use_shamt = 1'b1; shamt = instr[10:6]; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDIU: begin f = ALU_ADD;  use_imm = 1'b1; imm = sext16(instr[15:0]); end
      OP_SLTI:  begin f = ALU_SLT;  use_imm = 1'b1; imm = sext16(instr[15:0]); end
      OP_SLTIU: begin f = ALU_SLTU; use_imm = 1'b1; imm = sext16(instr[15:0]); end
      OP_ANDI:  begin f = ALU_AND;  use_imm = 1'b1; imm = zext16(instr[15:0]); end
      OP_ORI:   begin f = ALU_OR;   use_imm = 1'b1; imm = zext16(instr[15:0]); end
      OP_XORI:  begin f = ALU_XOR;  use_imm = 1'b1; imm = zext16(instr[15:0]); end
      // LUI runs as 0 | (imm << 16), so the rs operand is forced to zero
      OP_LUI: begin
        f       = ALU_OR;
        use_imm = 1'b1;
        imm     = {instr[15:0], 16'h0000};
        zero_vs = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (use_imm) rd = instr[20:16];
    // Illegal encodings leave as a NOP so execute needs no special case
    if (!legal) begin
      f         = ALU_ADD;
      use_imm   = 1'b0;
      use_shamt = 1'b0;
      rd        = 5'd0;
      shamt     = 5'd0;
      imm       = 32'h0;
      zero_vs   = 1'b0;
    end
  end

  always_comb begin
    control                = 6'h00;
    control[3:0]           = f;
    control[CTL_USE_IMM]   = use_imm;
    control[CTL_USE_SHAMT] = use_shamt;
  end

  assign illegal = !legal;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage. Decodes the fetched word, reads the register
// file with EX/WB forwarding and registers the bundle for execute.
//   clk, reset          clock, async active-high reset
//   bus (slave)         fetch-side and execute-side handshakes + bundle
//   ra1/ra2, rd1/rd2    register file read port (data is combinational)
//   fwd_ex_*, fwd_wb_*  forwarding sources; rd==0 means no forward
module decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus,
  output logic [4:0]    ra1,
  output logic [4:0]    ra2,
  input  logic [31:0]   rd1,
  input  logic [31:0]   rd2,
  input  logic [4:0]    fwd_ex_rd,
  input  logic [31:0]   fwd_ex_data,
  input  logic [4:0]    fwd_wb_rd,
  input  logic [31:0]   fwd_wb_data
);

  localparam id_bundle_t BND_RST = '{control: 6'h00, rd: 5'd0, shamt: 5'd0,
                                     vs: 32'h0, vt: 32'h0, imm: 32'h0,
                                     pc: RESET_PC, illegal: 1'b0};

  logic        valid_q, valid_d;
  id_bundle_t  bnd_q, bnd_d;

  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [5:0]  dec_control;
  logic [31:0] dec_imm;
  logic        dec_illegal, dec_zero_vs;
  logic [31:0] opnd_s, opnd_t;
  logic        accept;

  instr_decoder u_dec (
    .instr   (bus.instr),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .control (dec_control),
    .rd      (dec_rd),
    .shamt   (dec_shamt),
    .imm     (dec_imm),
    .illegal (dec_illegal),
    .zero_vs (dec_zero_vs)
  );

  assign ra1 = dec_rs;
  assign ra2 = dec_rt;

  // EX is younger than WB, so it wins; $0 is hardwired regardless of rf data
  function automatic logic [31:0] resolve(input logic [4:0]  a,
                                          input logic [31:0] rf,
                                          input logic [4:0]  exr,
                                          input logic [31:0] exd,
                                          input logic [4:0]  wbr,
                                          input logic [31:0] wbd);
    if (a == 5'd0)      return 32'h0;
    else if (a == exr)  return exd;
    else if (a == wbr)  return wbd;
    else                return rf;
  endfunction

  assign opnd_s = resolve(dec_rs, rd1, fwd_ex_rd, fwd_ex_data, fwd_wb_rd, fwd_wb_data);
  assign opnd_t = resolve(dec_rt, rd2, fwd_ex_rd, fwd_ex_data, fwd_wb_rd, fwd_wb_data);

  assign bus.in_ready = !valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    bnd_d   = bnd_q;
    // Flush only clears valid; data is left as-is since nothing consumes it
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d       = 1'b1;
      bnd_d.control = dec_control;
      bnd_d.rd      = dec_rd;
      bnd_d.shamt   = dec_shamt;
      bnd_d.vs      = (dec_zero_vs | dec_illegal) ? 32'h0 : opnd_s;
      bnd_d.vt      = dec_illegal ? 32'h0 : opnd_t;
      bnd_d.imm     = dec_imm;
      bnd_d.pc      = bus.pc_in;
      bnd_d.illegal = dec_illegal;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      bnd_q   <= BND_RST;
    end else begin
      valid_q <= valid_d;
      bnd_q   <= bnd_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.control   = bnd_q.control;
  assign bus.rd        = bnd_q.rd;
  assign bus.shamt     = bnd_q.shamt;
  assign bus.vs        = bnd_q.vs;
  assign bus.vt        = bnd_q.vt;
  assign bus.imm       = bnd_q.imm;
  assign bus.pc_out    = bnd_q.pc;
  assign bus.illegal   = bnd_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed test-plan cases plus randomized traffic, all
// checked against a behavioural model of the ID stage kept in this bench.
module tb_decode_stage;

  localparam logic [31:0] RPC = 32'hbfc0_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if bus();

  logic [4:0]  ra1, ra2, ex_rd, wb_rd;
  logic [31:0] rd1, rd2, ex_data, wb_data;
  logic [31:0] rf [32];
  logic [31:0] pc_ctr;

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  decode_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .fwd_ex_rd(ex_rd), .fwd_ex_data(ex_data),
    .fwd_wb_rd(wb_rd), .fwd_wb_data(wb_data)
  );

  typedef struct packed {
    logic [5:0]  ctl;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] vs, vt, imm, pc;
    logic        ill;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  bit   exp_v;
  exp_t exp_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---- reference model ----
  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 0) return 0;
    if (a == ex_rd) return ex_data;
    if (a == wb_rd) return wb_data;
    return rf[a];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    int f = -1;
    int ext = 0;  // 0 none, 1 sign, 2 zero, 3 upper
    bit sh = 0;
    e = '0;
    e.pc = pc;
    if (op == 0) begin
      case (fn)
        'h21: f = 0;  'h23: f = 1;  'h24: f = 2;  'h25: f = 3;
        'h26: f = 4;  'h27: f = 5;  'h2a: f = 6;  'h2b: f = 7;
        'h00: begin f = 8;  sh = 1; end
        'h02: begin f = 9;  sh = 1; end
        'h03: begin f = 10; sh = 1; end
        default: f = -1;
      endcase
    end else begin
      case (op)
        'h09: begin f = 0; ext = 1; end
        'h0a: begin f = 6; ext = 1; end
        'h0b: begin f = 7; ext = 1; end
        'h0c: begin f = 2; ext = 2; end
        'h0d: begin f = 3; ext = 2; end
        'h0e: begin f = 4; ext = 2; end
        'h0f: begin f = 3; ext = 3; end
        default: f = -1;
      endcase
    end
    if (f < 0) begin
      e.ill = 1;
      return e;
    end
    e.ctl = 6'(f + (sh ? 32 : 0) + (op != 0 ? 16 : 0));
    e.rd  = (op == 0) ? w[15:11] : w[20:16];
    e.sh  = sh ? w[10:6] : 5'd0;
    case (ext)
      1: e.imm = 32'($signed(w[15:0]));
      2: e.imm = 32'(w[15:0]);
      3: e.imm = 32'(w[15:0]) * 65536;
      default: e.imm = 0;
    endcase
    e.vs = (ext == 3) ? 32'h0 : opnd(w[25:21]);
    e.vt = opnd(w[20:16]);
    return e;
  endfunction

  task automatic model_reset();
    exp_v = 0;
    exp_b = '0;
    exp_b.pc = RPC;
  endtask

  task automatic model_update();
    bit acc = bus.in_valid && (!exp_v || bus.out_ready);
    if (bus.flush) exp_v = 0;
    else if (acc) begin
      exp_v = 1;
      exp_b = ref_decode(bus.instr, bus.pc_in);
    end else if (bus.out_ready) exp_v = 0;
  endtask

  task automatic check_state();
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    if (exp_v) begin
      chk("control", 32'(bus.control), 32'(exp_b.ctl));
      chk("rd",      32'(bus.rd),      32'(exp_b.rd));
      chk("shamt",   32'(bus.shamt),   32'(exp_b.sh));
      chk("vs",      bus.vs,           exp_b.vs);
      chk("vt",      bus.vt,           exp_b.vt);
      chk("imm",     bus.imm,          exp_b.imm);
      chk("pc_out",  bus.pc_out,       exp_b.pc);
      chk("illegal", 32'(bus.illegal), 32'(exp_b.ill));
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] w, input logic orr, input logic fl);
    bus.in_valid  = iv;
    bus.instr     = w;
    bus.pc_in     = pc_ctr;
    bus.out_ready = orr;
    bus.flush     = fl;
    pc_ctr        = pc_ctr + 4;
  endtask

  // called at a negedge with inputs already driven
  task automatic cycle();
    #1 chk("in_ready", 32'(bus.in_ready), 32'(!exp_v || bus.out_ready));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_state();
  endtask

  function automatic logic [31:0] rand_instr();
    int k = int'($urandom_range(0, 19));
    logic [31:0] w = $urandom;
    logic [5:0]  op, fn;
    op = 6'h00;
    fn = 6'h00;
    case (k)
      0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h24;  3: fn = 6'h25;
      4: fn = 6'h26;  5: fn = 6'h27;  6: fn = 6'h2a;  7: fn = 6'h2b;
      8: fn = 6'h00;  9: fn = 6'h02;  10: fn = 6'h03;
      default: op = 6'(k - 2);
    endcase
    if (k >= 18) return w;  // arbitrary word, often illegal
    w[31:26] = op;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    if (op == 6'h00) w[5:0] = fn;
    return w;
  endfunction

  initial begin
    pc_ctr = 32'h0000_1000;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hdead_beef;  // must never be seen as an operand
    ex_rd = 0; wb_rd = 0; ex_data = 0; wb_data = 0;
    reset = 1'b1;
    drive(0, 32'h0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst control",   32'(bus.control),   0);
    chk("rst rd",        32'(bus.rd),        0);
    chk("rst vs",        bus.vs,             0);
    chk("rst imm",       bus.imm,            0);
    chk("rst illegal",   32'(bus.illegal),   0);
    chk("rst pc_out",    bus.pc_out,         RPC);
    model_reset();
    reset = 1'b0;

    // ADDIU $3,$1,-4
    rf[1] = 32'd7;
    drive(1, 32'h2423FFFC, 1, 0); cycle();
    chk("addiu control", 32'(bus.control), 32'h10);
    chk("addiu rd",      32'(bus.rd), 3);
    chk("addiu vs",      bus.vs, 7);
    chk("addiu imm",     bus.imm, 32'hFFFFFFFC);

    // SLL $2,$5,4 then ORI $4,$0,0x8000
    rf[5] = 32'd1;
    drive(1, 32'h00051100, 1, 0); cycle();
    chk("sll control", 32'(bus.control), 32'h28);
    chk("sll rd",      32'(bus.rd), 2);
    chk("sll shamt",   32'(bus.shamt), 4);
    chk("sll vt",      bus.vt, 1);
    drive(1, 32'h34048000, 1, 0); cycle();
    chk("ori control", 32'(bus.control), 32'h13);
    chk("ori imm",     bus.imm, 32'h00008000);
    chk("ori vs",      bus.vs, 0);

    // forwarding priority on ADDU $6,$1,$1
    rf[1] = 32'h77; ex_rd = 1; ex_data = 32'h55; wb_rd = 1; wb_data = 32'h66;
    drive(1, 32'h00213021, 1, 0); cycle();
    chk("fwd ex vs", bus.vs, 32'h55);
    chk("fwd ex vt", bus.vt, 32'h55);
    ex_rd = 0;
    drive(1, 32'h00213021, 1, 0); cycle();
    chk("fwd wb vs", bus.vs, 32'h66);
    drive(1, 32'h00003021, 1, 0); cycle();
    chk("r0 vs", bus.vs, 0);
    chk("r0 vt", bus.vt, 0);
    wb_rd = 0;

    // backpressure: hold for 3 cycles, then back-to-back replacement
    rf[1] = 32'h11;
    drive(1, 32'h00213021, 1, 0); cycle();
    rf[1] = 32'h99;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h2423FFFC, 0, 0); cycle();
      chk("hold in_ready", 32'(bus.in_ready), 0);
      chk("hold rd",       32'(bus.rd), 6);
      chk("hold vs",       bus.vs, 32'h11);
    end
    drive(1, 32'h2423FFFC, 1, 0); cycle();
    chk("release valid", 32'(bus.out_valid), 1);
    chk("release rd",    32'(bus.rd), 3);
    chk("release vs",    bus.vs, 32'h99);

    // illegal, then flush squashes held + incoming
    drive(1, 32'hFC000000, 1, 0); cycle();
    chk("ill valid",   32'(bus.out_valid), 1);
    chk("ill illegal", 32'(bus.illegal), 1);
    chk("ill control", 32'(bus.control), 0);
    chk("ill rd",      32'(bus.rd), 0);
    drive(1, 32'h2423FFFC, 0, 1); cycle();
    chk("flush valid", 32'(bus.out_valid), 0);

    // async reset between edges
    drive(1, 32'h00213021, 1, 0); cycle();
    drive(0, 32'h0, 1, 0);
    #2 reset = 1'b1;
    #1 chk("async rst valid", 32'(bus.out_valid), 0);
    chk("async rst pc", bus.pc_out, RPC);
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    rf[1] = 32'd7;
    drive(1, 32'h2423FFFC, 1, 0); cycle();
    chk("post rst control", 32'(bus.control), 32'h10);
    chk("post rst rd",      32'(bus.rd), 3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = $urandom;
      ex_rd   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      wb_rd   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      ex_data = $urandom;
      wb_data = $urandom;
      drive(logic'($urandom_range(0, 9) < 7), rand_instr(),
            logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the five-stage MIPS core.
- Accepts fetched instruction words over a valid/ready handshake and decodes the integer ALU subset.
- Reads the register file and resolves operands with EX/WB forwarding.
- Registers the {control, rd, shamt, vs, vt, imm} bundle the execute stage consumes: control[3:0] ALU funct, control[4] selects imm, control[5] selects shamt.

Parameters:
- RESET_PC, 32'hbfc0_0000, value of pc_out after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept instruction this cycle
- instr  in  32  instruction word
- pc_in  in  32  instruction address
- flush  in  1  squash held and incoming instruction
- ra1  out  5  register file read address (rs)
- ra2  out  5  register file read address (rt)
- rd1  in  32  register file read data 1, combinational
- rd2  in  32  register file read data 2, combinational
- fwd_ex_rd  in  5  EX destination (0 = none)
- fwd_ex_data  in  32  EX result
- fwd_wb_rd  in  5  WB destination (0 = none)
- fwd_wb_data  in  32  WB data
- out_valid  out  1  bundle valid to execute
- out_ready  in  1  execute accepts bundle
- control  out  6  {use_shamt, use_imm, alu_funct[3:0]}
- rd  out  5  destination register
- shamt  out  5  shift amount
- vs  out  32  rs operand
- vt  out  32  rt operand
- imm  out  32  extended immediate
- pc_out  out  32  address of bundle
- illegal  out  1  bundle came from an unsupported encoding

Behaviour:
- Reset (async, active-high): out_valid=0, control=0, rd=0, shamt=0, vs=0, vt=0, imm=0, illegal=0, pc_out=RESET_PC.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Instruction accepted when in_valid & in_ready; the bundle is registered on that edge, so latency is 1 cycle.
  - out_valid falls after an out_ready cycle with no new accept.
- Holding: while out_valid & !out_ready, all outputs hold stable.
- Flush has priority over accept: next cycle out_valid=0, and the incoming instruction is dropped. Data registers may be left unchanged.
- Register reads and forwarding:
  - ra1=instr[25:21], ra2=instr[20:16].
  - Operand priority: EX match > WB match > register file. A match requires a nonzero address equal to the forward rd.
  - Register 0 always reads 0.
- Decode: unlisted fields are don't-care; any other opcode/funct is illegal.
  - R-type (op 0):
    - ADDU 21 → ADD; SUBU 23 → SUB; AND 24; OR 25; XOR 26; NOR 27; SLT 2A; SLTU 2B. For these, control[5:4]=00 and rd=instr[15:11].
    - SLL 00, SRL 02, SRA 03 → control[5]=1, shamt=instr[10:6].
  - I-type: control[4]=1, rd=instr[20:16].
    - ADDIU 09, SLTI 0A, SLTIU 0B: sign-extended immediate.
    - ANDI 0C, ORI 0D, XORI 0E: zero-extended immediate.
    - LUI 0F: imm={instr[15:0],16'b0}, funct OR, vs forced to 0.
- Illegal instruction: registered as a NOP (control=0, rd=0, vs=vt=imm=0, shamt=0) with illegal=1, still out_valid=1.
- shamt field: 0 for non-shift instructions.
- Destination 0 (e.g. ADDU $0,...) passes through as rd=0; no special case.
- Simultaneous accept + out_ready: new bundle replaces old in the same edge; no bubble.

Decomposition:
- Package mips_pkg:
  - opcode/funct constants.
  - alu_funct_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=A.
  - control bit indices.
  - Shared with execute and alu.
- Sub-module: combinational instr_decoder (instr → control, rd, shamt, imm, illegal, zero_vs). decode_stage owns forwarding and the pipeline register.

Test Plan:
- 0x2423FFFC (ADDIU $3,$1,-4), rd1=7 → next cycle out_valid=1, control=0x10, rd=3, vs=7, imm=0xFFFFFFFC.
- 0x00051100 (SLL $2,$5,4), rd2=0x1 → control=0x28, rd=2, shamt=4, vt=1; 0x34048000 (ORI $4,$0,0x8000) → control=0x13, imm=0x00008000, vs=0.
- ADDU $6,$1,$1 with fwd_ex_rd=1/0x55, fwd_wb_rd=1/0x66, rd1=0x77 → vs=vt=0x55; with fwd_ex_rd=0 → 0x66; with register 0 source and fwd_ex_rd=0 → 0.
- Backpressure: bundle valid, out_ready=0 for 3 cycles with new in_valid → in_ready=0, outputs unchanged; out_ready=1 with in_valid → next bundle presented the following cycle, no bubble.
- Illegal instr 0xFC000000 → out_valid=1, illegal=1, control=0, rd=0; flush asserted with in_valid → next cycle out_valid=0.
- Reset asserted mid-stream (async, between edges) → out_valid=0 and pc_out=0xBFC00000 immediately; after release, first accepted instruction is decoded normally.
